// File: rtl/cpu_run_ctrl.sv
// Run/step controller: debounced buttons drive a one-cycle core tick enable.
// Optional breakpoint compare enabled by CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl_db #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_cnt;
  logic            r_lvl;
  logic            r_press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt   <= '0;
        r_lvl   <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_press = r_press;
endmodule

module cpu_run_ctrl #(
  parameter int DIV_DEFAULT = 12500000,
  parameter int CNT_W       = 32,
  parameter int DEBOUNCE    = 250000,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             tick,
  output logic [1:0]       state,
  output logic             hb_led
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  ,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_set,
  input  logic             bp_clr,
  output logic             bp_hit
`endif
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;
  logic             r_hb;
  logic             w_run_p;
  logic             w_step_p;
  logic [CNT_W-1:0] w_div_new;
  logic [CNT_W-1:0] w_last;

  cpu_run_ctrl_db #(.DEBOUNCE(DEBOUNCE)) u_run_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (run_btn),
    .o_press (w_run_p)
  );

  cpu_run_ctrl_db #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (step_btn),
    .o_press (w_step_p)
  );

  // A zero ratio would never reach terminal count; treat it as 1.
  assign w_div_new = (div_value == '0) ? CNT_W'(1) : div_value;
  assign w_last    = r_div - CNT_W'(1);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic            r_bp_arm;
  logic [PC_W-1:0] r_bp_addr;
  logic            r_bp_hit;
  logic            w_bp_match;
  logic            w_bp_take;

  assign w_bp_match = r_bp_arm && (pc == r_bp_addr);
  assign w_bp_take  = (r_state == S_RUN) && !halt && !w_run_p
                      && w_bp_match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bp_arm  <= 1'b0;
      r_bp_addr <= '0;
      r_bp_hit  <= 1'b0;
    end else begin
      if (bp_set) begin
        r_bp_addr <= bp_addr;
        r_bp_arm  <= 1'b1;
      end else if (bp_clr) begin
        r_bp_arm <= 1'b0;
      end
      if (w_bp_take) r_bp_hit <= 1'b1;
      else if (w_run_p || w_step_p) r_bp_hit <= 1'b0;
    end
  end

  assign bp_hit = r_bp_hit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= CNT_W'(DIV_DEFAULT);
      r_tick  <= 1'b0;
      r_hb    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (div_load) r_div <= w_div_new;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (halt) begin
            r_state <= S_HALT;
          end else if (w_run_p) begin
            r_state <= S_RUN;
          end else if (w_step_p) begin
            r_state <= S_STEP;
            r_tick  <= 1'b1;
            r_hb    <= ~r_hb;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (w_run_p) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
          else if (w_bp_match) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
`endif
          else if (div_load) begin
            r_cnt <= '0;
          end else if (r_cnt == w_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_hb   <= ~r_hb;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STEP: begin
          r_cnt   <= '0;
          r_state <= halt ? S_HALT : S_IDLE;
        end
        S_HALT: begin
          r_cnt <= '0;
          if (w_run_p && !halt) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tick   = r_tick;
  assign state  = r_state;
  assign hb_led = r_hb;
endmodule
